serial_frame_tx: RTL
====================

Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter for the 9-bit word bus; the transmit counterpart of the serial frame receiver used by the Verilog front-end regression designs.
- Accepts one word per valid/ready handshake and emits a framed bit stream: start bit, data LSB-first, optional even parity, stop bit.
- Sits between a word producer (testbench task or FIFO) and a single-wire line, which may carry a pullup on the board model.

Parameters:
- WIDTH, 9: data word width; legal range 1..32.
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal range 1..65535.
- PARITY_EN, 1: 1 inserts an even-parity bit after data; 0 omits it.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_data  input  WIDTH  word to transmit; sampled only at acceptance.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept; high only in IDLE.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when the stop bit finishes.

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE, tx=1, busy=0, done=0, bit and clock counters=0, shift register=0. in_ready=1 after reset. Reset during a frame aborts it immediately; tx returns to 1 with no glitch to 0.
- Acceptance: rising edge with in_valid && in_ready. in_data is latched into the shift register, and parity is computed as the XOR-reduce of in_data. The state becomes START at that edge.
- tx is registered. Each state holds tx for exactly CLKS_PER_BIT cycles, counted by a clock counter of width clog2(CLKS_PER_BIT+1) that reloads at every bit boundary.
- State sequence and tx value per state:
  - START: tx=0.
  - DATA: WIDTH bits, LSB first. tx=shreg[0]; logical right shift at each bit boundary. A bit index counter runs 0..WIDTH-1.
  - PARITY: present only if PARITY_EN=1. tx=parity, giving an even total count of 1s across data plus parity.
  - STOP: tx=1.
- STOP end: state returns to IDLE, and done=1 for exactly that one cycle.
- Frame length: (1+WIDTH+PARITY_EN+1)*CLKS_PER_BIT cycles. tx takes the start-bit value on the first cycle after the acceptance edge.
- Back-to-back frames: in_ready=1 in the cycle after done. With in_valid held high, the minimum idle gap between stop and the next start is 1 clock cycle at tx=1.
- in_valid asserted while busy: ignored. in_data may change freely while busy.
- in_ready is combinational from state only: in_ready = (state==IDLE).
- CLKS_PER_BIT=1: every bit lasts 1 cycle, and counters must not underflow.
- No X may reach tx: every state assigns tx, and the default case drives 1 and returns to IDLE.

Decomposition:
- Package serial_frame_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP) as a 3-bit typedef;
  - localparams for the idle, start and stop line levels;
  - a function frame_bits(width, parity_en) returning the frame length in bits.
  The receiver shares this package.
- One sub-module, serial_bit_timer: a counter of CLKS_PER_BIT cycles with load/tick outputs, reused by the receiver.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> tx=1, busy=0, done=0, in_ready=1 throughout. No acceptance occurs.
- Single frame, defaults, in_data=9'h0A5:
  - tx bit sequence is 0, then 1,0,1,0,0,1,0,1,0, then parity 0, then 1.
  - Each bit lasts 4 cycles, for 48 cycles total.
  - done pulses exactly once, 48 cycles after the acceptance edge.
- Parity odd data: in_data=9'h001 -> parity bit=1.
  - Repeat with PARITY_EN=0 -> 11-bit frame lasting 44 cycles, with stop immediately after data bit 8.
- Back-to-back: in_valid held high with words 9'h1FF then 9'h000 -> second start bit begins 1 cycle after the first frame's done.
  - Changing in_data mid-frame does not alter the bits transmitted.
- Mid-frame reset: assert rst_n=0 during DATA bit 4 -> tx=1 in the same cycle, without waiting for a clock edge.
  - After release, a new word 9'h155 transmits a correct full frame.
- CLKS_PER_BIT=1, WIDTH=1, in_data=1 -> tx sequence 0,1,1,1 over 4 cycles; done on the 4th cycle.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmitter and receiver:
// FSM states, line levels and frame-length arithmetic.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    // Bits on the wire for one frame: start + data + optional parity + stop.
    function automatic int unsigned frame_bits(input int unsigned width, input bit parity_en);
        return width + (parity_en ? 32'd1 : 32'd0) + 32'd2;
    endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: tick is high in the last cycle of each serial bit;
// load restarts a full CLKS_PER_BIT period.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Saturates at zero so a one-cycle bit period never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out framed transmitter: start bit, data LSB-first,
// optional even parity, stop bit. tx is registered and idles high.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH        = 9,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    // Handshake: a word is taken on a rising edge where in_valid && in_ready;
    // in_ready depends on state only and is high exactly in IDLE.

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [BW-1:0]    bit_idx;
    logic             parity;
    logic             accept;
    logic             tick;
    logic             timer_load;

    assign in_ready   = (state == ST_IDLE);
    assign busy       = ~in_ready;
    assign accept     = in_ready & in_valid;
    assign shreg_next = shreg >> 1;
    assign timer_load = accept | (busy & tick);

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (timer_load),
        .tick (tick)
    );

    // tx is loaded with the value of the state being entered, so each line
    // level appears on the cycle right after the boundary edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tx      <= LINE_IDLE;
            done    <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
            parity  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx <= LINE_IDLE;
                    if (in_valid) begin
                        shreg   <= in_data;
                        parity  <= ^in_data;
                        bit_idx <= '0;
                        tx      <= LINE_START;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx    <= shreg[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg <= shreg_next;
                        if (bit_idx == LAST_BIT) begin
                            if (PARITY_EN) begin
                                tx    <= parity;
                                state <= ST_PARITY;
                            end else begin
                                tx    <= LINE_STOP;
                                state <= ST_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                            tx      <= shreg_next[0];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tx    <= LINE_STOP;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        tx    <= LINE_IDLE;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    tx    <= LINE_IDLE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
